// File: rtl/legv8_pipe_hazard_ctrl.sv
// Hazard controller for the pipelined LEGv8 core: a scoreboard of in-flight writers drives
// load-use stalls, branch flushes, registered forwarding selects and stall/flush counters.
module legv8_pipe_hazard_ctrl #(
   parameter  int RA_W     = 5,
   parameter  int STAGES   = 3,
   parameter  int LOAD_LAT = 1,
   parameter  int BR_STAGE = 1,
   parameter  int ZERO_REG = 31,
   parameter  int CNT_W    = 32,
   localparam int FW_W     = $clog2(STAGES)
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic                id_valid,
   input  logic [RA_W-1:0]     id_rn,
   input  logic [RA_W-1:0]     id_rm,
   input  logic                id_use_rn,
   input  logic                id_use_rm,
   input  logic [RA_W-1:0]     id_rd,
   input  logic                id_reg_write,
   input  logic                id_mem_read,
   input  logic                branch_taken,
   output logic                pc_write,
   output logic                ifid_write,
   output logic                ifid_flush,
   output logic                idex_bubble,
   output logic [BR_STAGE-1:0] kill,
   output logic [FW_W-1:0]     fwd_a,
   output logic [FW_W-1:0]     fwd_b,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    flush_cnt
);

   localparam logic [RA_W-1:0] ZR = RA_W'(ZERO_REG);

   logic [STAGES-1:0] sbV;
   logic [STAGES-1:0] sbWr;
   logic [STAGES-1:0] sbLd;
   logic [RA_W-1:0]   sbRd [STAGES];

   logic            hitA;
   logic            hitB;
   int              idxA;
   int              idxB;
   logic            loadUse;
   logic            stall;
   logic            bubble;
   logic [FW_W-1:0] fwdNextA;
   logic [FW_W-1:0] fwdNextB;

   // Scanning from the oldest entry down leaves the youngest match in hit/idx.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      hitA = 1'b0;
      hitB = 1'b0;
      idxA = 0;
      idxB = 0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (sbV[k] && sbWr[k] && id_use_rn && (id_rn != ZR) && (sbRd[k] == id_rn)) begin
            hitA = 1'b1;
            idxA = k;
         end
         if (sbV[k] && sbWr[k] && id_use_rm && (id_rm != ZR) && (sbRd[k] == id_rm)) begin
            hitB = 1'b1;
            idxB = k;
         end
      end
   end

   always_comb begin
      loadUse  = id_valid && ((hitA && sbLd[idxA] && (idxA < LOAD_LAT)) ||
                              (hitB && sbLd[idxB] && (idxB < LOAD_LAT)));
      stall    = loadUse && !branch_taken;
      bubble   = stall || branch_taken;
      fwdNextA = (hitA && (idxA <= STAGES - 2)) ? FW_W'(idxA + 1) : '0;
      fwdNextB = (hitB && (idxB <= STAGES - 2)) ? FW_W'(idxB + 1) : '0;
   end

   assign pc_write    = !stall;
   assign ifid_write  = !stall;
   assign ifid_flush  = branch_taken;
   assign idex_bubble = bubble;
   assign kill        = {BR_STAGE{branch_taken}};

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         sbV       <= '0;
         sbWr      <= '0;
         sbLd      <= '0;
         fwd_a     <= '0;
         fwd_b     <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         // A taken branch squashes everything younger than the branch as it advances.
         for (int k = STAGES - 1; k > 0; k--) begin
            sbV[k]  <= sbV[k-1] && !(branch_taken && ((k - 1) < BR_STAGE));
            sbWr[k] <= sbWr[k-1];
            sbLd[k] <= sbLd[k-1];
         end
         sbV[0]  <= id_valid && !bubble;
         sbWr[0] <= id_reg_write && (id_rd != ZR);
         sbLd[0] <= id_mem_read;

         fwd_a <= (bubble || !id_valid) ? '0 : fwdNextA;
         fwd_b <= (bubble || !id_valid) ? '0 : fwdNextB;

         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (branch_taken && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   // NOTE: destination fields carry no reset; an entry's valid bit qualifies them.
   always_ff @(posedge CLOCK) begin
      for (int k = STAGES - 1; k > 0; k--)
         sbRd[k] <= sbRd[k-1];
      sbRd[0] <= id_rd;
   end

endmodule
